branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the pipelined core.
- Lets the front end steer fetch at IF instead of waiting for branch resolution in MEM.
- Holds a direct-mapped BTB with one 2-bit saturating counter per entry. It is looked up combinationally with the fetch PC and updated from the resolved-branch stage.
- Also generates the mispredict/redirect signal and saturating performance counters.

---
 rtl/bp_pkg.sv | 17 +
 rtl/sat_ctr2.sv | 19 +
 rtl/branch_predictor.sv | 130 +++++++++++++
 tb/tb_branch_predictor.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared encodings and constants for the BTB-based branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam int MODE_STATIC  = 0;
    localparam int MODE_BIMODAL = 1;

    localparam logic [1:0] CTR_ALLOC = CTR_WT;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating counter next-state: count up on taken, down on not taken.
module sat_ctr2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup at IF,
// registered training from the resolve stage, mispredict/redirect and perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 16,
    parameter int MODE    = 1,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            tbl_flush,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       ctr;
    } btb_entry_t;

    btb_entry_t tbl_q [ENTRIES];

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    btb_entry_t       if_ent, upd_ent, upd_entry_d;
    logic             if_hit, upd_hit, upd_we;
    logic [1:0]       upd_ctr_next;

    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    // Byte-offset bits of either PC never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    // Lookup path
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[XLEN-1:IDX_W+2];
    assign if_ent = tbl_q[if_idx];
    assign if_hit = if_ent.valid && (if_ent.tag == if_tag);

    assign pred_taken  = if_valid && !reset && (MODE == MODE_BIMODAL) && if_hit && if_ent.ctr[1];
    assign pred_target = pred_taken ? if_ent.target : (if_pc + PC_STEP);

    // Update path
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
    assign upd_ent = tbl_q[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    sat_ctr2 u_upd_ctr (
        .ctr      (upd_ent.ctr),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    // Flush takes priority over training; a not-taken miss never allocates.
    always_comb begin
        upd_we      = 1'b0;
        upd_entry_d = upd_ent;
        if (upd_valid && !tbl_flush) begin
            if (upd_hit) begin
                upd_we          = 1'b1;
                upd_entry_d.ctr = upd_ctr_next;
                if (upd_taken) upd_entry_d.target = upd_target;
            end else if (upd_taken) begin
                upd_we             = 1'b1;
                upd_entry_d.valid  = 1'b1;
                upd_entry_d.tag    = upd_tag;
                upd_entry_d.target = upd_target;
                upd_entry_d.ctr    = CTR_ALLOC;
            end
        end
    end

    assign mispredict  = upd_valid && ((upd_pred_taken != upd_taken) ||
                                       (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = upd_taken ? upd_target : (upd_pc + PC_STEP);

    // Perf counters stick at all-ones rather than wrapping.
    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (upd_valid && !(&br_count_q))      br_count_d      = br_count_q + CNT_W'(1);
        if (mispredict && !(&mispred_count_q)) mispred_count_d = mispred_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid <= 1'b0;
                tbl_q[i].ctr   <= CTR_RESET;
            end
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (tbl_flush) begin
                for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
            end else if (upd_we) begin
                tbl_q[upd_idx] <= upd_entry_d;
            end
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench: bimodal (CNT_W=32) and static (CNT_W=4) predictors share stimulus, checked against a table model.
module tb_branch_predictor;

    localparam int XL  = 64;
    localparam int ENT = 16;
    localparam int IW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, if_valid, tbl_flush, upd_valid, upd_taken, upd_pred_taken;
    logic [XL-1:0] if_pc, upd_pc, upd_target, upd_pred_target;

    logic          b_pt, s_pt, b_mp, s_mp;
    logic [XL-1:0] b_tgt, s_tgt, b_rd, s_rd;
    logic [31:0]   b_br, b_mc;
    logic [3:0]    s_br, s_mc;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.XLEN(XL), .ENTRIES(ENT), .MODE(1), .CNT_W(32)) u_bim (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(b_pt), .pred_target(b_tgt), .tbl_flush(tbl_flush),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(b_mp), .redirect_pc(b_rd),
        .br_count(b_br), .mispred_count(b_mc)
    );

    branch_predictor #(.XLEN(XL), .ENTRIES(ENT), .MODE(0), .CNT_W(4)) u_sta (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(s_pt), .pred_target(s_tgt), .tbl_flush(tbl_flush),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(s_mp), .redirect_pc(s_rd),
        .br_count(s_br), .mispred_count(s_mc)
    );

    // Reference model: what each table slot remembers, plus event tallies.
    logic          m_valid [ENT];
    logic [XL-1:0] m_tag   [ENT];
    logic [XL-1:0] m_tgt   [ENT];
    int            m_ctr   [ENT];
    int            m_br, m_mis;

    function automatic int idx_of(logic [XL-1:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic logic [XL-1:0] tag_of(logic [XL-1:0] pc);
        return pc >> (IW + 2);
    endfunction

    function automatic logic m_hit(logic [XL-1:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic logic m_pred(logic [XL-1:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [XL-1:0] m_ptgt(logic [XL-1:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 64'd4;
    endfunction

    function automatic logic e_pt();
        return if_valid && !reset && m_pred(if_pc);
    endfunction

    function automatic logic [XL-1:0] e_tgt();
        return e_pt() ? m_tgt[idx_of(if_pc)] : if_pc + 64'd4;
    endfunction

    function automatic logic e_mp();
        return upd_valid && ((upd_pred_taken != upd_taken) ||
                             (upd_taken && upd_pred_target != upd_target));
    endfunction

    function automatic logic [XL-1:0] e_rd();
        return upd_taken ? upd_target : upd_pc + 64'd4;
    endfunction

    function automatic logic [3:0] sat4(int n);
        return (n > 15) ? 4'hF : 4'(n);
    endfunction

    task automatic drv(input logic ifv, input logic [XL-1:0] ifpc, input logic fl,
                       input logic uv, input logic [XL-1:0] upc, input logic ut,
                       input logic [XL-1:0] utgt, input logic upt, input logic [XL-1:0] uptgt);
        if_valid = ifv; if_pc = ifpc; tbl_flush = fl;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_pred_taken = upt; upd_pred_target = uptgt;
        #1;
    endtask

    task automatic idle(input logic [XL-1:0] ifpc);
        drv(1'b1, ifpc, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic tick();
        logic mp;
        int   i;
        mp = e_mp();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < ENT; k++) begin m_valid[k] = 1'b0; m_ctr[k] = 1; end
            m_br = 0; m_mis = 0;
        end else begin
            if (upd_valid) m_br++;
            if (mp) m_mis++;
            if (tbl_flush) begin
                for (int k = 0; k < ENT; k++) m_valid[k] = 1'b0;
            end else if (upd_valid) begin
                i = idx_of(upd_pc);
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                        m_tgt[i] = upd_target;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1'b1; m_tag[i] = tag_of(upd_pc);
                    m_tgt[i] = upd_target; m_ctr[i] = 2;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drv(1'b1, 64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h80, 1'b0, '0);
        total++; if (b_pt !== 1'b0) begin bad++; $display("FAIL reset_pred_in_reset: got %0b want 0", b_pt); end
        tick(); tick();
        reset = 1'b0;
        idle(64'h100);
        total++; if (b_pt !== 1'b0) begin bad++; $display("FAIL reset_pred: got %0b want 0", b_pt); end
        total++; if (b_tgt !== 64'h104) begin bad++; $display("FAIL reset_tgt: got %h want 104", b_tgt); end
        total++; if (b_br !== 32'd0 || b_mc !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", b_br, b_mc); end
        total++; if (s_br !== 4'd0 || s_mc !== 4'd0) begin bad++; $display("FAIL reset_cnt_s: got %0d/%0d want 0/0", s_br, s_mc); end
        idle(64'hFFFF_FFFF_FFFF_FFFC);
        total++; if (b_tgt !== 64'h0) begin bad++; $display("FAIL tgt_wrap: got %h want 0", b_tgt); end
    endtask

    task automatic test_basic();
        drv(1'b1, 64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 64'h104);
        total++; if (b_mp !== 1'b1) begin bad++; $display("FAIL basic_misp: got %0b want 1", b_mp); end
        total++; if (b_rd !== 64'h80) begin bad++; $display("FAIL basic_redirect: got %h want 80", b_rd); end
        tick();
        idle(64'h100);
        total++; if (b_pt !== 1'b1 || b_tgt !== 64'h80) begin bad++; $display("FAIL basic_lookup: got %0b/%h want 1/80", b_pt, b_tgt); end
        total++; if (s_pt !== 1'b0 || s_tgt !== 64'h104) begin bad++; $display("FAIL basic_static: got %0b/%h want 0/104", s_pt, s_tgt); end
        total++; if (b_mc !== 32'd1 || b_br !== 32'd1) begin bad++; $display("FAIL basic_cnt: got %0d/%0d want 1/1", b_br, b_mc); end
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 3; n++) begin
            drv(1'b1, 64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h80, 1'b1, 64'h80);
            tick();
        end
        for (int n = 0; n < 2; n++) begin
            drv(1'b1, 64'h100, 1'b0, 1'b1, 64'h100, 1'b0, 64'h80, 1'b1, 64'h80);
            total++; if (b_mp !== 1'b1 || b_rd !== 64'h104) begin bad++; $display("FAIL sat_nt_misp: got %0b/%h want 1/104", b_mp, b_rd); end
            tick();
        end
        idle(64'h100);
        total++; if (b_pt !== 1'b0 || b_tgt !== 64'h104) begin bad++; $display("FAIL sat_down: got %0b/%h want 0/104", b_pt, b_tgt); end
        for (int n = 0; n < 3; n++) begin
            drv(1'b1, 64'h100, 1'b0, 1'b1, 64'h100, 1'b0, 64'h80, 1'b0, 64'h0);
            tick();
        end
        drv(1'b1, 64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 64'h0);
        tick();
        idle(64'h100);
        total++; if (b_pt !== e_pt() || b_pt !== 1'b0) begin bad++; $display("FAIL sat_floor: got %0b want 0", b_pt); end
        total++; if (b_mc !== 32'(m_mis) || b_br !== 32'(m_br)) begin bad++; $display("FAIL sat_cnt: got %0d/%0d want %0d/%0d", b_br, b_mc, m_br, m_mis); end
    endtask

    task automatic test_alias();
        drv(1'b0, 64'h0, 1'b0, 1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 64'h0);
        tick();
        drv(1'b0, 64'h0, 1'b0, 1'b1, 64'h140, 1'b1, 64'h300, 1'b0, 64'h0);
        tick();
        idle(64'h140);
        total++; if (b_pt !== 1'b1 || b_tgt !== 64'h300) begin bad++; $display("FAIL alias_new: got %0b/%h want 1/300", b_pt, b_tgt); end
        idle(64'h100);
        total++; if (b_pt !== 1'b0 || b_tgt !== 64'h104) begin bad++; $display("FAIL alias_old: got %0b/%h want 0/104", b_pt, b_tgt); end
        idle(64'h103);
        total++; if (b_tgt !== 64'h107) begin bad++; $display("FAIL alias_lowbits: got %h want 107", b_tgt); end
    endtask

    task automatic test_same_cycle();
        int br0;
        drv(1'b0, 64'h0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        tick();
        drv(1'b1, 64'h200, 1'b0, 1'b1, 64'h200, 1'b1, 64'h280, 1'b0, 64'h0);
        total++; if (b_pt !== 1'b0 || b_tgt !== 64'h204) begin bad++; $display("FAIL same_cycle_old: got %0b/%h want 0/204", b_pt, b_tgt); end
        tick();
        idle(64'h200);
        total++; if (b_pt !== 1'b1 || b_tgt !== 64'h280) begin bad++; $display("FAIL same_cycle_new: got %0b/%h want 1/280", b_pt, b_tgt); end
        br0 = m_br;
        drv(1'b1, 64'h300, 1'b1, 1'b1, 64'h300, 1'b1, 64'h380, 1'b0, 64'h0);
        tick();
        idle(64'h300);
        total++; if (b_pt !== 1'b0 || b_tgt !== 64'h304) begin bad++; $display("FAIL flush_wins: got %0b/%h want 0/304", b_pt, b_tgt); end
        total++; if (b_br !== 32'(br0 + 1)) begin bad++; $display("FAIL flush_counts: got %0d want %0d", b_br, br0 + 1); end
        idle(64'h200);
        total++; if (b_pt !== 1'b0) begin bad++; $display("FAIL flush_clears: got %0b want 0", b_pt); end
    endtask

    task automatic test_static_sat();
        for (int n = 0; n < 16; n++) begin
            drv(1'b1, 64'h100, 1'b0, 1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 64'h0);
            total++; if (s_pt !== 1'b0) begin bad++; $display("FAIL static_pred: got %0b want 0", s_pt); end
            tick();
        end
        idle(64'h100);
        total++; if (s_br !== 4'hF) begin bad++; $display("FAIL static_br_sat: got %h want f", s_br); end
        total++; if (s_mc !== sat4(m_mis)) begin bad++; $display("FAIL static_mc_sat: got %h want %h", s_mc, sat4(m_mis)); end
        total++; if (b_br !== 32'(m_br) || b_pt !== 1'b1) begin bad++; $display("FAIL bim_after_train: got %0d/%0b want %0d/1", b_br, b_pt, m_br); end
    endtask

    function automatic logic [XL-1:0] pick_pc();
        logic [XL-1:0] pc;
        pc = 64'h100 + 64'(4 * $urandom_range(0, 7)) + 64'(64 * $urandom_range(0, 2)) + 64'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) pc = {$urandom, $urandom};
        return pc;
    endfunction

    task automatic test_random();
        logic [XL-1:0] upc, tgt;
        logic          ut, upt;
        logic [XL-1:0] uptgt;
        for (int n = 0; n < 400; n++) begin
            upc = pick_pc();
            ut  = $urandom_range(0, 1);
            tgt = ($urandom_range(0, 1) != 0) ? 64'h1000 + 64'(4 * $urandom_range(0, 3)) : {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                upt = m_pred(upc); uptgt = m_ptgt(upc);
            end else begin
                upt = $urandom_range(0, 1); uptgt = tgt;
            end
            drv($urandom_range(0, 3) != 0, pick_pc(), $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) != 0, upc, ut, tgt, upt, uptgt);
            total++;
            if (b_pt !== e_pt() || b_tgt !== e_tgt()) begin
                bad++; $display("FAIL rnd_lookup[%0d]: got %0b/%h want %0b/%h", n, b_pt, b_tgt, e_pt(), e_tgt());
            end
            total++;
            if (s_pt !== 1'b0 || s_tgt !== if_pc + 64'd4) begin
                bad++; $display("FAIL rnd_static[%0d]: got %0b/%h want 0/%h", n, s_pt, s_tgt, if_pc + 64'd4);
            end
            total++;
            if (b_mp !== e_mp() || s_mp !== e_mp() || (e_mp() && (b_rd !== e_rd() || s_rd !== e_rd()))) begin
                bad++; $display("FAIL rnd_misp[%0d]: got %0b/%h want %0b/%h", n, b_mp, b_rd, e_mp(), e_rd());
            end
            total++;
            if (b_br !== 32'(m_br) || b_mc !== 32'(m_mis) || s_br !== sat4(m_br) || s_mc !== sat4(m_mis)) begin
                bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d %0d/%0d want %0d/%0d", n, b_br, b_mc, s_br, s_mc, m_br, m_mis);
            end
            tick();
        end
    endtask

    task automatic test_midreset();
        for (int n = 0; n < 2; n++) begin
            drv(1'b0, 64'h0, 1'b0, 1'b1, 64'h180, 1'b1, 64'h500, 1'b0, 64'h0);
            tick();
        end
        idle(64'h180);
        total++; if (b_pt !== 1'b1) begin bad++; $display("FAIL midrst_trained: got %0b want 1", b_pt); end
        reset = 1'b1;
        drv(1'b1, 64'h180, 1'b0, 1'b1, 64'h1C0, 1'b1, 64'h600, 1'b0, 64'h0);
        total++; if (b_pt !== 1'b0) begin bad++; $display("FAIL midrst_gate: got %0b want 0", b_pt); end
        tick();
        reset = 1'b0;
        idle(64'h180);
        total++; if (b_pt !== 1'b0 || b_tgt !== 64'h184) begin bad++; $display("FAIL midrst_clear: got %0b/%h want 0/184", b_pt, b_tgt); end
        idle(64'h1C0);
        total++; if (b_pt !== 1'b0) begin bad++; $display("FAIL midrst_noalloc: got %0b want 0", b_pt); end
        total++; if (b_br !== 32'd0 || b_mc !== 32'd0 || s_br !== 4'd0 || s_mc !== 4'd0) begin
            bad++; $display("FAIL midrst_cnt: got %0d/%0d %0d/%0d want 0", b_br, b_mc, s_br, s_mc);
        end
        // Reset counters to 01: one taken update on a fresh allocation still lands at 10 -> taken.
        drv(1'b0, 64'h0, 1'b0, 1'b1, 64'h180, 1'b1, 64'h700, 1'b0, 64'h0);
        tick();
        idle(64'h180);
        total++; if (b_pt !== e_pt() || b_tgt !== 64'h700) begin bad++; $display("FAIL post_rst_alloc: got %0b/%h want 1/700", b_pt, b_tgt); end
    endtask

    initial begin
        for (int k = 0; k < ENT; k++) begin m_valid[k] = 1'b0; m_ctr[k] = 1; m_tag[k] = '0; m_tgt[k] = '0; end
        m_br = 0; m_mis = 0;
        reset = 1'b1;
        drv(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        test_reset();
        test_basic();
        test_saturate();
        test_alias();
        test_same_cycle();
        test_static_sat();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
